// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-128 input loader slice.
package aes_pkg;

    localparam int AES_DATA_W    = 128;
    localparam int AES_WORD_W    = 32;
    localparam int WORDS_PER_BLK = AES_DATA_W / AES_WORD_W;
    localparam int CNT_W         = $clog2(WORDS_PER_BLK);

    typedef enum logic [1:0] {
        NO_KEY = 2'd0,
        SETTLE = 2'd1,
        READY  = 2'd2
    } state_e;

endpackage

// File: rtl/aes_word_packer.sv
// Packs host words MSW-first into 128-bit groups, latching the group type and aborting on a type switch.
// Define AES_LOADER_BYTE_SWAP_EN to byte-reverse every accepted word before packing.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BLK_W  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              is_key_i,
    output logic [BLK_W-1:0]  packed_o,
    output logic              done_o,
    output logic              done_is_key_o,
    output logic              abort_o
);

    logic [WORD_W-1:0]       word_sw;
    logic [BLK_W-WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    type_q, type_d;
    logic                    mismatch;

`ifdef AES_LOADER_BYTE_SWAP_EN
    for (genvar b = 0; b < WORD_W / 8; b++) begin : g_swap
        assign word_sw[8*b +: 8] = word_i[WORD_W-8-8*b +: 8];
    end
`else
    assign word_sw = word_i;
`endif

    assign mismatch      = accept_i && (cnt_q != '0) && (is_key_i != type_q);
    assign packed_o      = {shift_q, word_sw};
    assign done_o        = accept_i && !mismatch && (cnt_q == CNT_W'(WORDS_PER_BLK - 1));
    assign done_is_key_o = type_q;
    assign abort_o       = mismatch;

    // An offending word restarts the group as its first word, so it reloads like count 0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        if (accept_i) begin
            if ((cnt_q == '0) || mismatch) begin
                type_d  = is_key_i;
                shift_d = {{(BLK_W-2*WORD_W){1'b0}}, word_sw};
                cnt_d   = CNT_W'(1);
            end else begin
                shift_d = {shift_q[BLK_W-2*WORD_W-1:0], word_sw};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            type_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

endmodule

// File: rtl/aes_input_loader.sv
// Host word stream to AES-128 core loader: assembles keys/blocks and blocks data during the post-key settle window.
// Optional AES_LOADER_BYTE_SWAP_EN (handled in aes_word_packer) selects little-endian host words.
module aes_input_loader
    import aes_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int KEY_LEN    = 128,
    parameter int WORD_W     = 32,
    parameter int KEY_SETTLE = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               word_valid_in,
    output logic               word_ready_out,
    input  logic [WORD_W-1:0]  word_in,
    input  logic               word_is_key,
    output logic [KEY_LEN-1:0] cipher_key,
    output logic               key_valid_out,
    output logic [DATA_W-1:0]  plain_text,
    output logic               data_valid_out,
    output logic               seq_err
);

    localparam int SETTLE_W = $clog2(KEY_SETTLE + 1);

    state_e               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [KEY_LEN-1:0]   cipher_key_q;
    logic [DATA_W-1:0]    plain_text_q;
    logic                 key_valid_q, data_valid_q, seq_err_q;

    logic                 accept;
    logic [DATA_W-1:0]    packed_w;
    logic                 done_w, done_is_key_w, abort_w;
    logic                 key_done, data_done;

    // Data words stall (never drop) until a key has been loaded and its round keys have settled.
    assign word_ready_out = (state_q == READY) ||
                            (((state_q == NO_KEY) || (state_q == SETTLE)) && word_is_key);
    assign accept         = word_valid_in && word_ready_out;
    assign key_done       = done_w && done_is_key_w;
    assign data_done      = done_w && !done_is_key_w;

    aes_word_packer #(
        .WORD_W (WORD_W),
        .BLK_W  (DATA_W)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .accept_i      (accept),
        .word_i        (word_in),
        .is_key_i      (word_is_key),
        .packed_o      (packed_w),
        .done_o        (done_w),
        .done_is_key_o (done_is_key_w),
        .abort_o       (abort_w)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            NO_KEY: ;
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = READY;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            READY: ;
            default: state_d = NO_KEY;
        endcase
        if (key_done) begin
            state_d  = SETTLE;
            settle_d = SETTLE_W'(KEY_SETTLE - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= NO_KEY;
            settle_q     <= '0;
            cipher_key_q <= '0;
            plain_text_q <= '0;
            key_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            key_valid_q  <= key_done;
            data_valid_q <= data_done;
            seq_err_q    <= abort_w;
            if (key_done) begin
                cipher_key_q <= packed_w[KEY_LEN-1:0];
            end
            if (data_done) begin
                plain_text_q <= packed_w;
            end
        end
    end

    assign cipher_key     = cipher_key_q;
    assign plain_text     = plain_text_q;
    assign key_valid_out  = key_valid_q;
    assign data_valid_out = data_valid_q;
    assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Scoreboard bench for aes_input_loader: expected keys/blocks are queued when driven and checked on each pulse.
module tb_aes_input_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wordValid = 1'b0;
    logic         wordIsKey = 1'b0;
    logic [31:0]  wordIn = '0;
    logic         wordReady;
    logic [127:0] cipherKey;
    logic [127:0] plainText;
    logic         keyValid, dataValid, seqErr;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    typedef struct {
        logic         isKey;
        logic [127:0] val;
        int           when;
    } exp_t;

    exp_t sbQ[$];
    int   seqQ[$];
    exp_t mon;

    aes_input_loader dut (
        .clk            (clk),
        .reset          (reset),
        .word_valid_in  (wordValid),
        .word_ready_out (wordReady),
        .word_in        (wordIn),
        .word_is_key    (wordIsKey),
        .cipher_key     (cipherKey),
        .key_valid_out  (keyValid),
        .plain_text     (plainText),
        .data_valid_out (dataValid),
        .seq_err        (seqErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] hostToCore(input logic [31:0] w);
`ifdef AES_LOADER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] mkBlock(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3);
        return {hostToCore(w0), hostToCore(w1), hostToCore(w2), hostToCore(w3)};
    endfunction

    // Offers one word and returns once it has transferred (or the wait budget expires).
    task automatic applyStimulus(input logic [31:0] w, input logic isKey, output int waited);
        wordValid = 1'b1;
        wordIn    = w;
        wordIsKey = isKey;
        waited    = 0;
        #1;
        while (!wordReady && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!wordReady) begin
            checkOutput("accept timeout", 128'd0, 128'd1);
            wordValid = 1'b0;
        end else begin
            @(posedge clk); #1;
            wordValid = 1'b0;
        end
    endtask

    task automatic sendGroup(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3, input logic isKey, output int when);
        int waited;
        exp_t e;
        applyStimulus(w0, isKey, waited); checkOutput("word0 stall", waited, 0);
        applyStimulus(w1, isKey, waited); checkOutput("word1 stall", waited, 0);
        applyStimulus(w2, isKey, waited); checkOutput("word2 stall", waited, 0);
        applyStimulus(w3, isKey, waited); checkOutput("word3 stall", waited, 0);
        e.isKey = isKey;
        e.val   = mkBlock(w0, w1, w2, w3);
        e.when  = cyc;
        when    = cyc;
        sbQ.push_back(e);
    endtask

    // Leaves a data word on the bus and counts cycles until the loader becomes ready for it.
    task automatic waitSettle(input logic [31:0] w);
        int n;
        wordValid = 1'b1;
        wordIn    = w;
        wordIsKey = 1'b0;
        n = 0;
        #1;
        while (!wordReady && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("settle window", n, 10);
    endtask

    always @(negedge clk) begin
        if (keyValid === 1'b1 || dataValid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected valid pulse", {keyValid, dataValid}, 2'b00);
            end else begin
                mon = sbQ.pop_front();
                checkOutput("pulse kind", {keyValid, dataValid}, mon.isKey ? 2'b10 : 2'b01);
                checkOutput("pulse cycle", cyc, mon.when);
                if (mon.isKey) checkOutput("cipher_key", cipherKey, mon.val);
                else           checkOutput("plain_text", plainText, mon.val);
            end
        end
        if (seqErr === 1'b1) begin
            if (seqQ.size() == 0) checkOutput("unexpected seq_err", 1, 0);
            else                  checkOutput("seq_err cycle", cyc, seqQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited, t1, t2, stalled;
        logic [127:0] heldBlock;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset cipher_key", cipherKey, 0);
        checkOutput("reset plain_text", plainText, 0);
        checkOutput("reset pulses", {keyValid, dataValid, seqErr}, 3'b000);
        reset = 1'b1;

        $display("[TB] data word before any key is stalled");
        wordValid = 1'b1; wordIn = 32'hdeadbeef; wordIsKey = 1'b0;
        #1;
        stalled = 0;
        for (int i = 0; i < 6; i++) begin
            if (!wordReady) stalled++;
            @(posedge clk); #1;
        end
        checkOutput("no-key data stall", stalled, 6);
        wordValid = 1'b0; wordIsKey = 1'b1;
        #1;
        checkOutput("no-key key ready", wordReady, 1);

        $display("[TB] key load and settle window");
        sendGroup(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 1'b1, t1);
        waitSettle(32'h00112233);

        $display("[TB] two back-to-back data blocks");
        sendGroup(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 1'b0, t1);
        sendGroup(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 1'b0, t2);
        checkOutput("block spacing", t2 - t1, 4);
        heldBlock = mkBlock(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);

        $display("[TB] type switch mid-group");
        applyStimulus(32'haaaa0000, 1'b0, waited);
        applyStimulus(32'haaaa0001, 1'b0, waited);
        applyStimulus(32'h10111213, 1'b1, waited);
        seqQ.push_back(cyc);
        applyStimulus(32'h14151617, 1'b1, waited);
        applyStimulus(32'h18191a1b, 1'b1, waited);
        applyStimulus(32'h1c1d1e1f, 1'b1, waited);
        sbQ.push_back('{1'b1, mkBlock(32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f), cyc});
        waitSettle(32'h5a5a0000);
        checkOutput("plain_text held", plainText, heldBlock);

        $display("[TB] partial group retained across idle gap");
        applyStimulus(32'h5a5a0000, 1'b0, waited);
        applyStimulus(32'h5a5a0001, 1'b0, waited);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(32'h5a5a0002, 1'b0, waited);
        applyStimulus(32'h5a5a0003, 1'b0, waited);
        sbQ.push_back('{1'b0, mkBlock(32'h5a5a0000, 32'h5a5a0001, 32'h5a5a0002, 32'h5a5a0003), cyc});

        $display("[TB] reset with partial data pending");
        applyStimulus(32'h66660000, 1'b0, waited);
        applyStimulus(32'h66660001, 1'b0, waited);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid reset cipher_key", cipherKey, 0);
        checkOutput("mid reset plain_text", plainText, 0);
        checkOutput("mid reset pulses", {keyValid, dataValid, seqErr}, 3'b000);
        reset = 1'b1;
        wordIsKey = 1'b0;
        #1;
        checkOutput("post reset data ready", wordReady, 0);
        @(posedge clk); #1;

        sendGroup(32'h20212223, 32'h24252627, 32'h28292a2b, 32'h2c2d2e2f, 1'b1, t1);
        waitSettle(32'h77770000);
        sendGroup(32'h77770000, 32'h77770001, 32'h77770002, 32'h77770003, 1'b0, t1);

`ifdef AES_LOADER_BYTE_SWAP_EN
        $display("[TB] little-endian key words");
        sendGroup(32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c, 1'b1, t1);
        @(negedge clk);
        checkOutput("swapped cipher_key", cipherKey, 128'h000102030405060708090a0b0c0d0e0f);
`endif

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 0);
        checkOutput("seq_err queue drained", seqQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
